// File: rtl/bus_gate_arbiter_if.sv
// Bus-gate handshake bundle: per-driver request/last in, one-hot tri-state enables out.
interface bus_gate_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] last;
  logic [NREQ-1:0] gate_en;
  logic [IDW-1:0]  owner;
  logic            bus_valid;
  logic            timeout;

  modport master (
    output req, last,
    input  gate_en, owner, bus_valid, timeout
  );

  modport slave (
    input  req, last,
    output gate_en, owner, bus_valid, timeout
  );
endinterface

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner of the shared system bus: registered one-hot gate enables,
// per-owner hold limit, optional all-off turnaround cycle between owners.
module bus_gate_arbiter #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bus_gate_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gate_q, gate_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            bus_valid_q, bus_valid_d;
  logic            timeout_q, timeout_d;

  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic            own_req, own_last, hold_full, release_own;

  // Rotating priority search starting at rr_ptr; first requester wins.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_found && bus.req[IDW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  assign own_req     = bus.req[owner_q];
  assign own_last    = bus.last[owner_q];
  assign hold_full   = (hold_cnt_q == CW'(MAX_HOLD));
  assign release_own = !own_req || own_last || hold_full;

  always_comb begin
    logic do_arb;
    state_d     = state_q;
    gate_d      = gate_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    bus_valid_d = bus_valid_q;
    timeout_d   = 1'b0;
    do_arb      = 1'b0;

    case (state_q)
      IDLE, TURN: do_arb = 1'b1;
      OWN: begin
        if (release_own) begin
          // Flag only releases forced purely by the hold limit.
          timeout_d = own_req && !own_last;
          if (TURNAROUND != 0) begin
            gate_d      = '0;
            bus_valid_d = 1'b0;
            state_d     = TURN;
          end else begin
            do_arb = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: begin
        gate_d      = '0;
        bus_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    if (do_arb) begin
      if (win_found) begin
        gate_d          = '0;
        gate_d[win_idx] = 1'b1;
        owner_d         = win_idx;
        bus_valid_d     = 1'b1;
        hold_cnt_d      = CW'(1);
        rr_ptr_d        = IDW'((int'(win_idx) + 1) % NREQ);
        state_d         = OWN;
      end else begin
        gate_d      = '0;
        bus_valid_d = 1'b0;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gate_q      <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
      bus_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_q      <= gate_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      bus_valid_q <= bus_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gate_en   = gate_q;
  assign bus.owner     = owner_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.timeout   = timeout_q;
endmodule
